// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch debouncer: FSM state encodings and default sizing.
package debounce_pkg;

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_CHECK  = 1'b1;

    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_STABLE_COUNT = 50000;
    localparam int unsigned DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/switch_debouncer_sync_chain.sv
// N-flop synchroniser bringing an asynchronous input into the clock domain.
module sync_chain #(
    parameter int unsigned N = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [N-1:0] stages;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], din};
        end
    end

    assign dout = stages[N-1];

endmodule

// File: rtl/switch_debouncer.sv
// Debounces a bouncy asynchronous switch into a clean registered level with edge strobes.
module switch_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic d,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync_out;
    logic [0:0]           state;
    logic [CNT_WIDTH-1:0] cnt;

    sync_chain #(.N(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .din   (raw_in),
        .dout  (sync_out)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_STABLE;
            cnt   <= '0;
            d     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_STABLE: begin
                    cnt  <= '0;
                    busy <= 1'b0;
                    if (sync_out != d) begin
                        state <= ST_CHECK;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (sync_out == d) begin
                        // Any matching sample means the change was a bounce.
                        state <= ST_STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        d     <= sync_out;
                        rise  <= sync_out;
                        fall  <= ~sync_out;
                        state <= ST_STABLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with SYNC_STAGES=2, STABLE_COUNT=4, CNT_WIDTH=3.
module tb_switch_debouncer;

    logic clock;
    logic reset;
    logic raw_in;
    logic d;
    logic rise;
    logic fall;
    logic busy;

    int total;
    int bad;

    typedef struct {
        logic raw;
        logic d;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vecs[21];

    switch_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_COUNT (4),
        .CNT_WIDTH    (3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .raw_in (raw_in),
        .d      (d),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic ed, input logic er,
                             input logic ef, input logic eb);
        check({tag, ".d"}, d, ed);
        check({tag, ".rise"}, rise, er);
        check({tag, ".fall"}, fall, ef);
        check({tag, ".busy"}, busy, eb);
    endtask

    // drive raw_in away from the edge, then sample just after the next rising edge
    task automatic step(input logic r);
        @(negedge clock);
        raw_in = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // rise: raw=1 held, d goes high at edge 6
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        // fall: raw=0 held, d goes low at edge 6
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        // short glitch: two cycles of 1 are rejected
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset held with raw_in=1 and the clock running
        reset  = 1'b0;
        raw_in = 1'b1;
        #1;
        check_all("reset_t0", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check_all("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        @(negedge clock);
        raw_in = 1'b0;
        reset  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].raw);
            check_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].rise,
                      vecs[i].fall, vecs[i].busy);
        end

        // reset asserted mid-qualification, between clock edges
        for (int i = 0; i < 4; i++) step(1'b1);
        check("mid_check.busy", busy, 1'b1);
        check("mid_check.d", d, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            check_all($sformatf("post_reset_e%0d", k), (k == 6), (k == 6), 1'b0,
                      (k >= 3 && k <= 5));
        end

        // continuous toggling never qualifies a new level
        for (int i = 0; i < 100; i++) begin
            step((i % 2) != 0);
            check("toggle.d", d, 1'b1);
            check("toggle.rise", rise, 1'b0);
            check("toggle.fall", fall, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b1);
        check_all("toggle_settle", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
